paddle_bbox_tracker: RTL
========================

Name: paddle_bbox_tracker

Overview:
- Sits directly downstream of the edge/colour-mask merge stage.
- Consumes its 1-bit merged paddle mask stream (merge_out / merge_out_valid) in raster order.
- Per frame, accumulates the bounding box and pixel count of set pixels. At end of frame, publishes box, centre and a found flag as a one-cycle result strobe for the game/VGA overlay logic.

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- X_W, 10, column coordinate width (>= clog2(WIDTH))
- Y_W, 9, row coordinate width (>= clog2(HEIGHT))
- CNT_W, 19, pixel counter width
- MIN_PIXELS, 64, minimum set pixels for found=1

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  mask pixel qualifier (merge_out_valid)
- in_pixel  in  1  mask pixel, 1 = paddle edge (merge_out)
- frame_sync  in  1  forces raster position to (0,0), discarding any partial frame
- res_valid  out  1  one-cycle result strobe
- found  out  1  last published frame had count >= MIN_PIXELS
- x_min, x_max  out  X_W  bounding-box columns
- y_min, y_max  out  Y_W  bounding-box rows
- x_ctr  out  X_W  (x_min+x_max)>>1
- y_ctr  out  Y_W  (y_min+y_max)>>1
- pix_count  out  CNT_W  set-pixel count of last published frame

Behaviour:
- Reset (async, reset_n=0): every output = 0; col/row counters = 0; accumulators initialised to empty; state = ACCUM.
- Raster counters: col and row advance only on cycles with in_valid=1.
  - col wraps WIDTH-1 -> 0 and increments row.
  - row wraps HEIGHT-1 -> 0.
  - in_valid=0 stalls everything (no accumulation, no advance).
- Empty accumulator state: xmin=all-ones, xmax=0, ymin=all-ones, ymax=0, cnt=0.
- Accumulate: when in_valid & in_pixel at (col,row):
  - xmin=min(xmin,col), xmax=max(xmax,col), ymin=min(ymin,row), ymax=max(ymax,row).
  - cnt=cnt+1, saturating at 2^CNT_W-1.
- FSM states:
  - ACCUM: accumulate. On the accepted pixel at (WIDTH-1,HEIGHT-1), include that pixel, snapshot the updated accumulators into a publish register, re-init accumulators to empty, go to PUBLISH.
  - PUBLISH (exactly one cycle): drive outputs from the snapshot. res_valid=1. found = snapshot cnt >= MIN_PIXELS. Return to ACCUM.
  - Any in_valid pixel arriving during PUBLISH is accumulated as pixel (0,0) of the new frame; no stall.
- Latency: res_valid asserts the cycle after the final pixel is accepted. Outputs are registered.
- found=0: box/centre outputs hold their previously published values. pix_count and found update every publish.
- Centre arithmetic: sum computed at X_W+1 / Y_W+1 bits, then shifted right by 1 (no overflow).
- frame_sync=1:
  - Counters and accumulators reset to empty; no publish for the partial frame.
  - If in_valid=1 in the same cycle, that pixel is accepted as (0,0) of the new frame.
  - If frame_sync coincides with the final pixel, sync wins: no publish.
- Reset asserted mid-frame or mid-PUBLISH: immediate return to reset state; res_valid drops asynchronously.

Optional Feature:
- Macro: PADDLE_ROI_EN.
- When defined:
  - Adds inputs roi_x0, roi_x1 (X_W) and roi_y0, roi_y1 (Y_W), sampled continuously.
  - Only set pixels with roi_x0<=col<=roi_x1 and roi_y0<=row<=roi_y1 are accumulated. Raster counting is unaffected.
- When undefined: no extra ports; the whole frame is accumulated.

Decomposition:
- Shared package paddle_loc_pkg:
  - Default WIDTH/HEIGHT and X_W/Y_W/CNT_W constants.
  - typedef bbox_t struct {xmin,xmax,ymin,ymax,cnt}.
  - State enum {ACCUM, PUBLISH}.
- One natural sub-module: raster_pos_counter (col/row counting with enable, sync clear and last-pixel flag). Reusable by other per-frame stages.

Test Plan (bench uses WIDTH=8, HEIGHT=4, MIN_PIXELS=2):
- Single frame, pixels set at (2,1),(5,1),(3,2), continuous in_valid -> res_valid one cycle after pixel 31; found=1, x_min=2, x_max=5, y_min=1, y_max=2, x_ctr=3, y_ctr=1, pix_count=3.
- Frame with one set pixel at (7,3) (the last pixel) -> pix_count=1, found=0, box outputs hold the previous frame's values.
- in_valid toggling 1/0 each cycle over a full frame with pixels (0,0),(7,3) -> identical result to continuous valid; res_valid follows the 32nd accepted pixel.
- frame_sync asserted at pixel 20 with several set pixels already accumulated -> no res_valid. The next full frame publishes only its own pixels, e.g. set (1,0) and (6,3) gives box 1..6 / 0..3.
- Reset pulsed mid-frame -> all outputs 0 immediately; the next full frame publishes correctly.
- With PADDLE_ROI_EN, ROI x 4..7, y 0..3, pixels (1,1),(5,2),(6,2) -> x_min=5, x_max=6, pix_count=2, found=1.

Source files
------------

// File: rtl/paddle_loc_pkg.sv
// Shared types and default geometry for per-frame paddle localisation stages.
package paddle_loc_pkg;

   localparam int unsigned DEF_WIDTH  = 640;
   localparam int unsigned DEF_HEIGHT = 480;
   localparam int unsigned DEF_X_W    = 10;
   localparam int unsigned DEF_Y_W    = 9;
   localparam int unsigned DEF_CNT_W  = 19;

   typedef struct packed {
      logic [DEF_X_W-1:0]   xmin;
      logic [DEF_X_W-1:0]   xmax;
      logic [DEF_Y_W-1:0]   ymin;
      logic [DEF_Y_W-1:0]   ymax;
      logic [DEF_CNT_W-1:0] cnt;
   } bbox_t;

   typedef enum logic {
      ACCUM   = 1'b0,
      PUBLISH = 1'b1
   } state_t;

   // Empty box: min fields at all-ones so the first set pixel always wins.
   localparam bbox_t BBOX_EMPTY = '{xmin: '1, xmax: '0, ymin: '1, ymax: '0, cnt: '0};

endpackage

// File: rtl/paddle_bbox_tracker_raster_pos_counter.sv
// Raster column/row counter with enable, synchronous clear and last-pixel flag.
// col_c/row_c give the position of the pixel presented this cycle (sync already applied).
module raster_pos_counter
   import paddle_loc_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned HEIGHT = DEF_HEIGHT,
   parameter int unsigned X_W    = DEF_X_W,
   parameter int unsigned Y_W    = DEF_Y_W
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           en,
   input  logic           sync,
   output logic [X_W-1:0] col_c,
   output logic [Y_W-1:0] row_c,
   output logic           last_c
);

   localparam logic [X_W-1:0] COL_LAST = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] ROW_LAST = Y_W'(HEIGHT - 1);

   logic [X_W-1:0] col_q;
   logic [Y_W-1:0] row_q;

   assign col_c  = sync ? '0 : col_q;
   assign row_c  = sync ? '0 : row_q;
   assign last_c = en && !sync && (col_c == COL_LAST) && (row_c == ROW_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q <= '0;
         row_q <= '0;
      end else if (en) begin
         if (col_c == COL_LAST) begin
            col_q <= '0;
            row_q <= (row_c == ROW_LAST) ? '0 : row_c + Y_W'(1);
         end else begin
            col_q <= col_c + X_W'(1);
            row_q <= row_c;
         end
      end else if (sync) begin
         col_q <= '0;
         row_q <= '0;
      end
   end

endmodule

// File: rtl/paddle_bbox_tracker.sv
// Per-frame bounding box / centre / pixel count of the merged paddle mask.
// Optional PADDLE_ROI_EN restricts accumulation to a rectangular region of interest.
module paddle_bbox_tracker
   import paddle_loc_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned HEIGHT     = DEF_HEIGHT,
   parameter int unsigned X_W        = DEF_X_W,
   parameter int unsigned Y_W        = DEF_Y_W,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned MIN_PIXELS = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic             in_pixel,
   input  logic             frame_sync,
`ifdef PADDLE_ROI_EN
   input  logic [X_W-1:0]   roi_x0,
   input  logic [X_W-1:0]   roi_x1,
   input  logic [Y_W-1:0]   roi_y0,
   input  logic [Y_W-1:0]   roi_y1,
`endif
   output logic             res_valid,
   output logic             found,
   output logic [X_W-1:0]   x_min,
   output logic [X_W-1:0]   x_max,
   output logic [Y_W-1:0]   y_min,
   output logic [Y_W-1:0]   y_max,
   output logic [X_W-1:0]   x_ctr,
   output logic [Y_W-1:0]   y_ctr,
   output logic [CNT_W-1:0] pix_count
);

   localparam int unsigned XS_W = DEF_X_W + 1;
   localparam int unsigned YS_W = DEF_Y_W + 1;

   logic [X_W-1:0]  col_c;
   logic [Y_W-1:0]  row_c;
   logic            last_c;
   logic            roi_ok_c;
   logic            hit_c;
   logic            found_c;
   logic [XS_W-1:0] x_sum_c;
   logic [YS_W-1:0] y_sum_c;
   bbox_t           acc_q;
   bbox_t           acc_nxt_c;
   state_t          state;

   raster_pos_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .X_W    (X_W),
      .Y_W    (Y_W)
   ) u_pos (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (in_valid),
      .sync    (frame_sync),
      .col_c   (col_c),
      .row_c   (row_c),
      .last_c  (last_c)
   );

`ifdef PADDLE_ROI_EN
   assign roi_ok_c = (col_c >= roi_x0) && (col_c <= roi_x1) &&
                     (row_c >= roi_y0) && (row_c <= roi_y1);
`else
   assign roi_ok_c = 1'b1;
`endif

   assign hit_c = in_valid && in_pixel && roi_ok_c;

   // Accumulator update; frame_sync restarts from empty with this cycle's pixel at (0,0).
   always_comb begin
      acc_nxt_c = frame_sync ? BBOX_EMPTY : acc_q;
      if (hit_c) begin
         if (DEF_X_W'(col_c) < acc_nxt_c.xmin) acc_nxt_c.xmin = DEF_X_W'(col_c);
         if (DEF_X_W'(col_c) > acc_nxt_c.xmax) acc_nxt_c.xmax = DEF_X_W'(col_c);
         if (DEF_Y_W'(row_c) < acc_nxt_c.ymin) acc_nxt_c.ymin = DEF_Y_W'(row_c);
         if (DEF_Y_W'(row_c) > acc_nxt_c.ymax) acc_nxt_c.ymax = DEF_Y_W'(row_c);
         if (acc_nxt_c.cnt != '1) acc_nxt_c.cnt = acc_nxt_c.cnt + DEF_CNT_W'(1);
      end
   end

   assign x_sum_c = XS_W'(acc_nxt_c.xmin) + XS_W'(acc_nxt_c.xmax);
   assign y_sum_c = YS_W'(acc_nxt_c.ymin) + YS_W'(acc_nxt_c.ymax);
   assign found_c = 32'(acc_nxt_c.cnt) >= MIN_PIXELS;

   // Output registers double as the publish snapshot, so res_valid lands the cycle after the last pixel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ACCUM;
         acc_q     <= BBOX_EMPTY;
         res_valid <= 1'b0;
         found     <= 1'b0;
         x_min     <= '0;
         x_max     <= '0;
         y_min     <= '0;
         y_max     <= '0;
         x_ctr     <= '0;
         y_ctr     <= '0;
         pix_count <= '0;
      end else begin
         if (state == PUBLISH) res_valid <= 1'b0;
         if (last_c) begin
            state     <= PUBLISH;
            acc_q     <= BBOX_EMPTY;
            res_valid <= 1'b1;
            found     <= found_c;
            pix_count <= CNT_W'(acc_nxt_c.cnt);
            if (found_c) begin
               x_min <= X_W'(acc_nxt_c.xmin);
               x_max <= X_W'(acc_nxt_c.xmax);
               y_min <= Y_W'(acc_nxt_c.ymin);
               y_max <= Y_W'(acc_nxt_c.ymax);
               x_ctr <= X_W'(x_sum_c >> 1);
               y_ctr <= Y_W'(y_sum_c >> 1);
            end
         end else begin
            state <= ACCUM;
            acc_q <= acc_nxt_c;
         end
      end
   end

endmodule
